// File: rtl/read_port_arbiter.sv
// Round-robin read arbiter for four requesters sharing one memory read port.
// One read in flight; all outputs registered; sticky timeout flag on memory timeout.
module read_port_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     req_enable,
  input  logic [3:0]                     req_request,
  input  logic [4*ADDRESS_BUS_WIDTH-1:0] req_address,
  output logic [15:0]                    req_data,
  output logic [3:0]                     req_finished_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0]   mem_address,
  output logic                           mem_read_strobe,
  input  logic [15:0]                    mem_read_data,
  input  logic                           mem_read_valid,
  output logic                           timeout_error,
  input  logic                           error_clear
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [1:0]                     grant;
  logic [1:0]                     grant_nxt;
  logic [1:0]                     last_grant;
  logic [1:0]                     last_grant_nxt;
  logic [7:0]                     tcount;
  logic [7:0]                     tcount_nxt;
  logic [3:0]                     eligible;
  logic                           any_eligible;
  logic [1:0]                     pick;
  logic                           grant_now;
  logic                           capture;
  logic                           timeout_hit;
  logic [15:0]                    req_data_nxt;
  logic [3:0]                     finished_nxt;
  logic [ADDRESS_BUS_WIDTH-1:0]   mem_address_nxt;
  logic                           mem_read_strobe_nxt;
  logic                           timeout_error_nxt;

  assign eligible     = req_request & req_enable;
  assign any_eligible = |eligible;
  assign grant_now    = (state == S_IDLE) && any_eligible;
  assign capture      = (state == S_WAIT) && mem_read_valid;
  // Valid wins over a timeout landing in the same cycle.
  assign timeout_hit  = (state == S_WAIT) && !mem_read_valid &&
                        ((tcount + 8'd1) == TIMEOUT_LIMIT);

  // Round-robin search starting just after the last served requester.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_grant + 2'(k + 1);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_eligible) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_read_valid) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath state.
  always_comb begin
    grant_nxt           = grant;
    last_grant_nxt      = last_grant;
    tcount_nxt          = tcount;
    mem_address_nxt     = mem_address;
    mem_read_strobe_nxt = 1'b0;
    req_data_nxt        = req_data;
    finished_nxt        = 4'b0000;
    timeout_error_nxt   = timeout_error;

    if (grant_now) begin
      grant_nxt           = pick;
      mem_address_nxt     = req_address[int'(pick)*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
      mem_read_strobe_nxt = 1'b1;
    end

    if (state == S_ISSUE) begin
      tcount_nxt = 8'd0;
    end else if ((state == S_WAIT) && !mem_read_valid) begin
      tcount_nxt = tcount + 8'd1;
    end

    if (capture) begin
      req_data_nxt = mem_read_data;
      finished_nxt = 4'b0001 << grant;
    end

    if ((state == S_DONE) || timeout_hit) begin
      last_grant_nxt = grant;
    end

    if (error_clear) begin
      timeout_error_nxt = 1'b0;
    end else if (timeout_hit) begin
      timeout_error_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant               <= 2'd0;
      last_grant          <= 2'd3;
      tcount              <= 8'd0;
      mem_address         <= '0;
      mem_read_strobe     <= 1'b0;
      req_data            <= 16'h0000;
      req_finished_strobe <= 4'b0000;
      timeout_error       <= 1'b0;
    end else begin
      grant               <= grant_nxt;
      last_grant          <= last_grant_nxt;
      tcount              <= tcount_nxt;
      mem_address         <= mem_address_nxt;
      mem_read_strobe     <= mem_read_strobe_nxt;
      req_data            <= req_data_nxt;
      req_finished_strobe <= finished_nxt;
      timeout_error       <= timeout_error_nxt;
    end
  end

endmodule

// File: doc/read_port_arbiter.md
READ_PORT_ARBITER -- requirements
Module: read_port_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_BUS_WIDTH, default 16, width of every address bus.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT-state cycles; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port req_enable, input, 4, per-requester enable mask; a requester whose bit is 0 is never granted.
REQ-006 SHALL have port req_request, input, 4, level read request per requester.
REQ-007 SHALL have port req_address, input, 4*ADDRESS_BUS_WIDTH, packed addresses; requester i at bits [i*W +: W].
REQ-008 SHALL have port req_data, output, 16, shared returned read data.
REQ-009 SHALL have port req_finished_strobe, output, 4, one-cycle data-ready strobe per requester.
REQ-010 SHALL have port mem_address, output, ADDRESS_BUS_WIDTH, memory read address.
REQ-011 SHALL have port mem_read_strobe, output, 1, one-cycle memory read command.
REQ-012 SHALL have port mem_read_data, input, 16, memory read data.
REQ-013 SHALL have port mem_read_valid, input, 1, one-cycle strobe qualifying mem_read_data.
REQ-014 SHALL have port timeout_error, output, 1, sticky flag set on memory timeout.
REQ-015 SHALL have port error_clear, input, 1, synchronous clear of timeout_error.

Function
REQ-016 SHALL register every output; none is combinational from an input.
REQ-017 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE; at most one memory read outstanding.
REQ-018 SHALL, in IDLE, grant the eligible requester (request & enable) first in round-robin order starting at last_grant+1 mod 4, latch its index and address, and enter ISSUE; with none eligible, stay in IDLE.
REQ-019 SHALL, in ISSUE, drive mem_read_strobe high for exactly that cycle with mem_address equal to the latched address, clear the timeout counter, and enter WAIT.
REQ-020 SHALL, in WAIT, on mem_read_valid capture mem_read_data into req_data and enter DONE.
REQ-021 SHALL, in DONE, assert req_finished_strobe[grant] for exactly that one cycle, set last_grant to grant, and return to IDLE.
REQ-022 SHALL hold req_data stable from DONE until the next capture.
REQ-023 SHALL give a grant-to-strobe latency of memory latency + 3 cycles (IDLE grant, ISSUE, WAIT..valid, DONE).
REQ-024 SHALL leave a requester at least one IDLE cycle after its strobe before it is re-sampled, so a stale level request is not re-granted.
REQ-025 SHALL treat mem_read_valid outside WAIT as spurious and ignore it, with no data capture and no strobe.
REQ-026 SHALL ignore request and address changes after the grant; the latched address is used.
REQ-027 SHALL increment an 8-bit timeout counter on each WAIT cycle without valid; when the counter equals TIMEOUT_CYCLES, set timeout_error, update last_grant to grant, and return to IDLE with no strobe.
REQ-028 SHALL give valid priority when it arrives in the same cycle the counter reaches TIMEOUT_CYCLES: normal completion, no error.
REQ-029 SHALL make error_clear win over a simultaneous timeout set.
REQ-030 SHALL grant a requester whose req_enable bit drops after grant through to completion.

Reset
REQ-031 SHALL, while rst is high, force FSM to IDLE, last_grant=3 (so requester 0 wins first), req_data=0, req_finished_strobe=0, mem_read_strobe=0, mem_address=0, timeout_error=0, timeout counter=0.
REQ-032 SHALL, on reset asserted mid-transaction, abandon the read with no strobe, and ignore a late mem_read_valid after release.

Verification
REQ-033 SHALL be verified by: single requester 2, memory latency 2 cycles, address 0x0123, data 0xBEEF -> one mem_read_strobe with mem_address 0x0123, req_data 0xBEEF, req_finished_strobe=4'b0100 exactly 5 cycles after grant.
REQ-034 SHALL be verified by: all four requesting continuously after reset -> grant order 0,1,2,3,0; no requester starved; exactly one strobe per read.
REQ-035 SHALL be verified by: req_enable=4'b1010, all requesting -> only requesters 1 and 3 granted, alternating.
REQ-036 SHALL be verified by: TIMEOUT_CYCLES=4, memory never responds -> timeout_error rises after 4 WAIT cycles, no strobe, next requester granted; error_clear drops it.
REQ-037 SHALL be verified by: valid in the same cycle the counter hits TIMEOUT_CYCLES -> normal strobe, timeout_error stays 0.
REQ-038 SHALL be verified by: rst pulsed during WAIT, then a late mem_read_valid -> all outputs at reset values, no strobe, FSM in IDLE.
